// File: rtl/cmos_multi_select.sv
// -----------------------------------------------------------------------------
// cmos_multi_select
//
// N-channel CMOS camera source selector. Two active-low push-buttons step a
// requested channel forward/backward with wrap-around; the request is only
// applied to the output mux at a vsync rise of the currently selected camera,
// or at once if that camera has stopped producing frames. Per-channel liveness
// is reported from a vsync-rise timeout counter.
//
// Ports:
//   clk            - system clock (single domain)
//   reset          - asynchronous, active-high reset
//   key_next       - "next channel" push-button, active low, asynchronous
//   key_prev       - "previous channel" push-button, active low, asynchronous
//   cmos_in_vsync  - per-channel vsync, channel i is bit i
//   cmos_in_href   - per-channel href
//   cmos_in_pclk   - per-channel pixel clock
//   cmos_in_d      - per-channel pixel data, channel i at [i*DATA_W +: DATA_W]
//   cmos_vsync     - vsync of the selected channel
//   cmos_href      - href of the selected channel
//   cmos_pclk      - pclk of the selected channel
//   cmos_d         - pixel data of the selected channel
//   sel_ch         - channel currently driving the outputs
//   req_ch         - channel requested by the buttons
//   switch_pending - high while req_ch differs from sel_ch
//   ch_alive       - bit i high if channel i had a vsync rise recently
// -----------------------------------------------------------------------------
module cmos_multi_select #(
    parameter int  NUM_CH       = 2,
    parameter int  DATA_W       = 8,
    parameter int  DEBOUNCE_CNT = 65534,
    parameter int  TIMEOUT_CYC  = 2000000,
    localparam int SEL_W        = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_next,
    input  logic                     key_prev,
    input  logic [NUM_CH-1:0]        cmos_in_vsync,
    input  logic [NUM_CH-1:0]        cmos_in_href,
    input  logic [NUM_CH-1:0]        cmos_in_pclk,
    input  logic [NUM_CH*DATA_W-1:0] cmos_in_d,
    output logic                     cmos_vsync,
    output logic                     cmos_href,
    output logic                     cmos_pclk,
    output logic [DATA_W-1:0]        cmos_d,
    output logic [SEL_W-1:0]         sel_ch,
    output logic [SEL_W-1:0]         req_ch,
    output logic                     switch_pending,
    output logic [NUM_CH-1:0]        ch_alive
);

    localparam int DB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam int LV_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CNT);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [LV_W-1:0]  LV_MAX  = LV_W'(TIMEOUT_CYC);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    // Index 0 is the "next" key, index 1 the "prev" key.
    logic [1:0]        key_raw;
    logic [1:0]        key_s1;
    logic [1:0]        key_s2;
    logic [1:0]        press;
    logic [DB_W-1:0]   db_cnt [2];

    logic [NUM_CH-1:0] vs_s1;
    logic [NUM_CH-1:0] vs_s2;
    logic [NUM_CH-1:0] vs_d;
    logic [NUM_CH-1:0] vs_rise;
    logic [LV_W-1:0]   live_cnt [NUM_CH];

    logic [SEL_W-1:0]  req_inc;
    logic [SEL_W-1:0]  req_dec;

    assign key_raw = {key_prev, key_next};

    // Two-flop synchronisers. Keys reset to the released (high) level so a
    // reset never looks like a press; vsync resets low so a channel that is
    // high at release still produces one clean rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            vs_s1  <= '0;
            vs_s2  <= '0;
            vs_d   <= '0;
        end else begin
            key_s1 <= key_raw;
            key_s2 <= key_s1;
            vs_s1  <= cmos_in_vsync;
            vs_s2  <= vs_s1;
            vs_d   <= vs_s2;
        end
    end

    // Debounce: the counter saturates, so the pulse (taken on the step from
    // DEBOUNCE_CNT-1 to DEBOUNCE_CNT) fires once per press however long the
    // key is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                db_cnt[k] <= '0;
            end
            press <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (key_s2[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] != DB_MAX) begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
                press[k] <= !key_s2[k] && (db_cnt[k] == DB_LAST);
            end
        end
    end

    // Registered vsync rise detect plus liveness timeout. Counters start
    // saturated so every channel reads dead until it shows a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_rise <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                live_cnt[i] <= LV_MAX;
            end
        end else begin
            vs_rise <= vs_s2 & ~vs_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (vs_rise[i]) begin
                    live_cnt[i] <= '0;
                end else if (live_cnt[i] != LV_MAX) begin
                    live_cnt[i] <= live_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ch_alive = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_alive[i] = (live_cnt[i] != LV_MAX);
        end
    end

    always_comb begin
        req_inc = (req_ch == LAST_CH) ? '0 : req_ch + 1'b1;
        req_dec = (req_ch == '0) ? LAST_CH : req_ch - 1'b1;
    end

    assign switch_pending = (req_ch != sel_ch);

    // Selection state. The commit samples req_ch before this edge's button
    // update, so a press landing on the commit cycle stays pending for the
    // next frame boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_ch <= '0;
            req_ch <= '0;
        end else begin
            if (switch_pending && (vs_rise[sel_ch] || !ch_alive[sel_ch])) begin
                sel_ch <= req_ch;
            end
            if (press[0] && !press[1]) begin
                req_ch <= req_inc;
            end else if (press[1] && !press[0]) begin
                req_ch <= req_dec;
            end
        end
    end

    always_comb begin
        cmos_vsync = cmos_in_vsync[0];
        cmos_href  = cmos_in_href[0];
        cmos_pclk  = cmos_in_pclk[0];
        cmos_d     = cmos_in_d[DATA_W-1:0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (sel_ch == SEL_W'(i)) begin
                cmos_vsync = cmos_in_vsync[i];
                cmos_href  = cmos_in_href[i];
                cmos_pclk  = cmos_in_pclk[i];
                cmos_d     = cmos_in_d[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_cmos_multi_select.sv
// -----------------------------------------------------------------------------
// tb_cmos_multi_select
//
// Self-checking bench for cmos_multi_select with NUM_CH=3, DEBOUNCE_CNT=4,
// TIMEOUT_CYC=100. Every cycle the DUT is compared with a reference model that
// works from the raw pin history: a press is a run of exactly DEBOUNCE_CNT low
// samples, a channel is alive if a vsync rise was registered within the last
// TIMEOUT_CYC cycles, and a pending request is applied at a rise or on a dead
// source. Directed scenarios, a key-press vector table and a random phase
// drive the stimulus.
// -----------------------------------------------------------------------------
module tb_cmos_multi_select;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int DEB    = 4;
    localparam int TMO    = 100;
    localparam int SEL_W  = 2;
    localparam int HALF   = 50;
    localparam int MAXC   = 8192;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     key_next = 1'b1;
    logic                     key_prev = 1'b1;
    logic [NUM_CH-1:0]        vs_pin = '0;
    logic [NUM_CH-1:0]        href_pin = '0;
    logic [NUM_CH-1:0]        pclk_pin = '0;
    logic [DATA_W-1:0]        d_pin [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] d_bus;

    logic                     cmos_vsync;
    logic                     cmos_href;
    logic                     cmos_pclk;
    logic [DATA_W-1:0]        cmos_d;
    logic [SEL_W-1:0]         sel_ch;
    logic [SEL_W-1:0]         req_ch;
    logic                     switch_pending;
    logic [NUM_CH-1:0]        ch_alive;

    assign d_bus = {d_pin[2], d_pin[1], d_pin[0]};

    cmos_multi_select #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .DEBOUNCE_CNT(DEB),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_next      (key_next),
        .key_prev      (key_prev),
        .cmos_in_vsync (vs_pin),
        .cmos_in_href  (href_pin),
        .cmos_in_pclk  (pclk_pin),
        .cmos_in_d     (d_bus),
        .cmos_vsync    (cmos_vsync),
        .cmos_href     (cmos_href),
        .cmos_pclk     (cmos_pclk),
        .cmos_d        (cmos_d),
        .sel_ch        (sel_ch),
        .req_ch        (req_ch),
        .switch_pending(switch_pending),
        .ch_alive      (ch_alive)
    );

    always #5 clk = ~clk;

    // Pin history, index n = value sampled at the n-th rising edge after reset.
    bit kn_hist [MAXC];
    bit kp_hist [MAXC];
    bit vs_hist [NUM_CH][MAXC];

    int cyc;
    int sel_m;
    int req_m;
    bit vs_en [NUM_CH];
    int vs_cnt [NUM_CH];
    bit seen_sel2;
    int compared;
    int mismatched;

    typedef struct {
        int kind;
        int low_len;
        int exp_req;
    } key_vec_t;

    key_vec_t vecs [11];

    function automatic bit key_at(int which, int idx);
        if (idx <= 0) return 1'b1;
        return (which == 0) ? kn_hist[idx] : kp_hist[idx];
    endfunction

    function automatic bit vs_at(int ch, int idx);
        if (idx <= 0) return 1'b0;
        return vs_hist[ch][idx];
    endfunction

    // Press pulse visible after edge m: the key was sampled low exactly DEB
    // times in a row, ending two edges earlier (synchroniser delay).
    function automatic bit press_at(int which, int m);
        if (!key_at(which, m - 2 - DEB)) return 1'b0;
        for (int k = m - 1 - DEB; k <= m - 2; k++) begin
            if (key_at(which, k)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Registered rise visible after edge m.
    function automatic bit rise_at(int ch, int m);
        return vs_at(ch, m - 2) && !vs_at(ch, m - 3);
    endfunction

    // Alive after edge m: a rise registered at some edge L with m-TMO <= L < m.
    function automatic bit alive_at(int ch, int m);
        for (int l = m - 1; l >= m - TMO && l >= 1; l--) begin
            if (rise_at(ch, l)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic model_update();
        int sel_next;
        bit pn;
        bit pp;
        sel_next = sel_m;
        if (req_m != sel_m && (rise_at(sel_m, cyc - 1) || !alive_at(sel_m, cyc - 1))) begin
            sel_next = req_m;
        end
        pn = press_at(0, cyc - 1);
        pp = press_at(1, cyc - 1);
        if (pn && !pp) begin
            req_m = (req_m == NUM_CH - 1) ? 0 : req_m + 1;
        end else if (pp && !pn) begin
            req_m = (req_m == 0) ? NUM_CH - 1 : req_m - 1;
        end
        sel_m = sel_next;
    endtask

    // One clock: record the pins the coming edge samples, advance the model,
    // refresh the camera pins after the edge and compare on the falling edge.
    task automatic step_cycle();
        logic [NUM_CH-1:0] alive_m;
        cyc++;
        if (cyc >= MAXC) begin
            $display("[TB] FAIL history_limit: cycle %0d, limit %0d", cyc, MAXC);
            $fatal(1, "[TB] history buffer exhausted");
        end
        kn_hist[cyc] = key_next;
        kp_hist[cyc] = key_prev;
        for (int ch = 0; ch < NUM_CH; ch++) vs_hist[ch][cyc] = vs_pin[ch];
        model_update();
        @(posedge clk);
        #1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (vs_en[ch]) begin
                vs_cnt[ch]++;
                if (vs_cnt[ch] == HALF) begin
                    vs_cnt[ch] = 0;
                    vs_pin[ch] = ~vs_pin[ch];
                end
            end
            d_pin[ch] = DATA_W'($urandom);
        end
        href_pin = NUM_CH'($urandom);
        pclk_pin = NUM_CH'($urandom);
        @(negedge clk);
        for (int ch = 0; ch < NUM_CH; ch++) alive_m[ch] = alive_at(ch, cyc);
        if (sel_ch == 2'd2) seen_sel2 = 1'b1;
        check_output("sel_ch", 32'(sel_ch), 32'(sel_m));
        check_output("req_ch", 32'(req_ch), 32'(req_m));
        check_output("switch_pending", 32'(switch_pending), 32'(req_m != sel_m));
        check_output("ch_alive", 32'(ch_alive), 32'(alive_m));
        check_output("cmos_d", 32'(cmos_d), 32'(d_pin[sel_m]));
        check_output("cmos_vsync", 32'(cmos_vsync), 32'(vs_pin[sel_m]));
        check_output("cmos_href", 32'(cmos_href), 32'(href_pin[sel_m]));
        check_output("cmos_pclk", 32'(cmos_pclk), 32'(pclk_pin[sel_m]));
    endtask

    // Asynchronous reset: outputs are checked 1 ns after assertion, before
    // any clock edge could have moved them.
    task automatic do_reset();
        @(negedge clk);
        key_next = 1'b1;
        key_prev = 1'b1;
        reset = 1'b1;
        #1;
        check_output("rst_sel_ch", 32'(sel_ch), 0);
        check_output("rst_req_ch", 32'(req_ch), 0);
        check_output("rst_pending", 32'(switch_pending), 0);
        check_output("rst_ch_alive", 32'(ch_alive), 0);
        check_output("rst_cmos_d", 32'(cmos_d), 32'(d_pin[0]));
        check_output("rst_cmos_vsync", 32'(cmos_vsync), 32'(vs_pin[0]));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        sel_m = 0;
        req_m = 0;
    endtask

    // kind: 0 = next, 1 = prev, 2 = both keys together.
    task automatic apply_stimulus(int kind, int low_len, int gap);
        if (kind != 1) key_next = 1'b0;
        if (kind != 0) key_prev = 1'b0;
        repeat (low_len) step_cycle();
        key_next = 1'b1;
        key_prev = 1'b1;
        repeat (gap) step_cycle();
    endtask

    task automatic wait_sel(int target, int budget);
        int k;
        k = 0;
        while (sel_ch !== SEL_W'(target) && k < budget) begin
            step_cycle();
            k++;
        end
        check_output("sel_reached", 32'(sel_ch), 32'(target));
    endtask

    task automatic wait_model_rise(int ch, int budget);
        bit found;
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            step_cycle();
            found = rise_at(ch, cyc);
        end
        check_output("vsync_rise_seen", 32'(found), 1);
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        cyc = 0;
        sel_m = 0;
        req_m = 0;
        seen_sel2 = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            d_pin[ch] = '0;
            vs_en[ch] = 1'b1;
            vs_cnt[ch] = ch * 15;
        end

        vecs[0]  = '{0, 1, 0};
        vecs[1]  = '{0, 3, 0};
        vecs[2]  = '{0, 4, 1};
        vecs[3]  = '{2, 6, 1};
        vecs[4]  = '{0, 5, 2};
        vecs[5]  = '{0, 20, 0};
        vecs[6]  = '{1, 3, 0};
        vecs[7]  = '{1, 4, 2};
        vecs[8]  = '{1, 20, 1};
        vecs[9]  = '{2, 20, 1};
        vecs[10] = '{0, 2, 1};

        // Reset state and steady operation on channel 0.
        do_reset();
        repeat (120) step_cycle();
        check_output("all_alive", 32'(ch_alive), 32'h7);
        check_output("idle_sel", 32'(sel_ch), 0);
        check_output("idle_req", 32'(req_ch), 0);
        check_output("idle_cmos_d", 32'(cmos_d), 32'(d_pin[0]));

        // Long next press: one step, applied at the next channel-0 frame.
        wait_model_rise(0, 200);
        apply_stimulus(0, 20, 4);
        check_output("next_req", 32'(req_ch), 1);
        check_output("next_pending", 32'(switch_pending), 1);
        check_output("next_sel_held", 32'(sel_ch), 0);
        wait_sel(1, 200);
        repeat (5) step_cycle();
        check_output("next_cmos_d", 32'(cmos_d), 32'(d_pin[1]));

        // Two prev presses inside one frame: 0 -> 2 -> 1, only 1 is applied.
        do_reset();
        repeat (120) step_cycle();
        wait_model_rise(0, 200);
        seen_sel2 = 1'b0;
        apply_stimulus(1, 6, 3);
        check_output("prev_wrap_req", 32'(req_ch), 2);
        apply_stimulus(1, 6, 3);
        check_output("prev_second_req", 32'(req_ch), 1);
        check_output("prev_pending", 32'(switch_pending), 1);
        wait_sel(1, 200);
        check_output("never_sel2", 32'(seen_sel2), 0);

        // Dead source: channel 0 stops, commit happens on the timeout.
        do_reset();
        repeat (120) step_cycle();
        vs_en[0] = 1'b0;
        vs_pin[0] = 1'b0;
        apply_stimulus(0, 8, 2);
        wait_sel(1, 300);
        check_output("dead_alive0", 32'(ch_alive[0]), 0);
        check_output("dead_req", 32'(req_ch), 1);
        vs_en[0] = 1'b1;

        // Key vector table: glitch lengths, simultaneous presses, wrap-around.
        do_reset();
        repeat (120) step_cycle();
        foreach (vecs[v]) begin
            apply_stimulus(vecs[v].kind, vecs[v].low_len, 4);
            check_output($sformatf("vec%0d_req", v), 32'(req_ch), 32'(vecs[v].exp_req));
        end

        // Random presses and on/off sources, checked by the model each cycle.
        repeat (40) begin
            if ($urandom_range(0, 7) == 0) begin
                int ch;
                ch = $urandom_range(0, NUM_CH - 1);
                vs_en[ch] = !vs_en[ch];
            end
            apply_stimulus($urandom_range(0, 2), $urandom_range(1, 8), $urandom_range(1, 12));
        end
        repeat (150) step_cycle();
        for (int ch = 0; ch < NUM_CH; ch++) vs_en[ch] = 1'b1;

        // Reset while a switch is pending: the request is discarded.
        do_reset();
        repeat (120) step_cycle();
        wait_model_rise(0, 200);
        apply_stimulus(0, 6, 3);
        check_output("pre_reset_pending", 32'(switch_pending), 1);
        do_reset();
        repeat (250) step_cycle();
        check_output("post_reset_sel", 32'(sel_ch), 0);
        check_output("post_reset_req", 32'(req_ch), 0);
        check_output("post_reset_pending", 32'(switch_pending), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cmos_multi_select.md
# cmos_multi_select

Parametrised N-channel CMOS camera source selector for the dual/multi-lens capture path. It sits between the camera input pins and the capture/frame-write logic. Two debounced push-buttons step the selection forward or backward with wrap-around. A new selection is applied only at a frame boundary of the currently selected camera, or immediately if that camera has stopped producing frames. The block also reports per-channel liveness.

## Interface
Parameters:
- NUM_CH, 2: number of camera channels, 2..8; SEL_W = max(1, clog2(NUM_CH)) is derived locally.
- DATA_W, 8: pixel data width per channel.
- DEBOUNCE_CNT, 65534: number of consecutive low samples that registers a key press.
- TIMEOUT_CYC, 2000000: clk cycles without a vsync rise before a channel counts as dead.

Ports:
- clk, in, 1: system clock, the single clock domain.
- reset, in, 1: asynchronous, active-high reset.
- key_next, in, 1: push-button, active low, asynchronous to clk.
- key_prev, in, 1: push-button, active low, asynchronous to clk.
- cmos_in_vsync, in, NUM_CH: per-channel vsync; channel i is bit i.
- cmos_in_href, in, NUM_CH: per-channel href.
- cmos_in_pclk, in, NUM_CH: per-channel pixel clock.
- cmos_in_d, in, NUM_CH*DATA_W: per-channel data; channel i occupies [i*DATA_W +: DATA_W].
- cmos_vsync, out, 1: vsync of the selected channel.
- cmos_href, out, 1: href of the selected channel.
- cmos_pclk, out, 1: pclk of the selected channel.
- cmos_d, out, DATA_W: data of the selected channel.
- sel_ch, out, SEL_W: active (applied) channel index.
- req_ch, out, SEL_W: requested channel index.
- switch_pending, out, 1: high while req_ch != sel_ch.
- ch_alive, out, NUM_CH: bit i high if channel i produced a vsync rise within the last TIMEOUT_CYC cycles.

## Operation
- Each key and each cmos_in_vsync bit passes through a 2-FF synchroniser into clk.
- Debounce, one counter per key:
  - Counter clears while the synchronised key is high.
  - It increments while the key is low and saturates at DEBOUNCE_CNT.
  - A 1-cycle press pulse fires on the cycle the counter transitions to DEBOUNCE_CNT. So there is exactly one pulse per press, regardless of hold time.
- Request update:
  - next pulse: req_ch <= (req_ch == NUM_CH-1) ? 0 : req_ch+1.
  - prev pulse: req_ch <= (req_ch == 0) ? NUM_CH-1 : req_ch-1.
  - Both pulses in the same cycle: no change.
  - Presses while pending keep moving req_ch; only the final value is applied.
- Vsync edge: rise_i = sync_vsync_i & ~sync_vsync_i_d (registered previous sample).
- Liveness, per-channel counter:
  - Cleared on rise_i; otherwise increments, saturating at TIMEOUT_CYC.
  - ch_alive[i] = (counter_i != TIMEOUT_CYC).
- Commit: when switch_pending, sel_ch <= req_ch on the cycle after either of:
  - rise of channel sel_ch, or
  - ch_alive[sel_ch] == 0.
  
  Otherwise sel_ch holds.
- Output mux is combinational from the registered sel_ch. Because switching occurs only at vsync rise (vertical blanking) or on a dead source, no partial frame is forwarded.
- Commit and a new press pulse in the same cycle: commit uses the pre-update req_ch; the new request stays pending.

## Timing
- Reset (asynchronous) values:
  - sel_ch = 0, req_ch = 0, switch_pending = 0.
  - ch_alive = 0: liveness counters reset to TIMEOUT_CYC.
  - All debounce counters = 0.
  - cmos_* outputs = channel 0 inputs.
- Key latency: after the key pin goes low, the press pulse fires DEBOUNCE_CNT+2 cycles later (2 synchroniser cycles), and req_ch/switch_pending update on the following edge.
- Vsync latency: a pin rise becomes rise_i 3 cycles later; sel_ch changes 1 cycle after that.
- Dead-source switch: applied 1 cycle after the pending request coexists with ch_alive[sel_ch] = 0.
- Reset mid-debounce or mid-pending: all state is discarded; no commit occurs after release until a new press.
- Key glitches shorter than DEBOUNCE_CNT cycles produce no pulse.

## Test plan
Bench settings: NUM_CH = 3, DEBOUNCE_CNT = 4, TIMEOUT_CYC = 100.

1. Reset then release; all vsync toggle every 50 cycles -> sel_ch = 0, req_ch = 0, ch_alive = 3'b111 after the first rises; cmos_d equals channel 0 data.
2. key_next low for 20 cycles -> exactly one pulse; req_ch = 1 and switch_pending = 1 until the next channel-0 vsync rise; sel_ch = 1 one cycle after that rise; cmos_d then tracks channel 1.
3. From sel_ch = 0, key_prev press -> req_ch = 2 (wrap). A second key_prev press before the frame edge -> req_ch = 1; the commit applies 1 and never passes through 2.
4. Stop channel-0 vsync, then press key_next -> commit occurs once counter_0 reaches 100 (ch_alive[0] = 0), without waiting for a vsync.
5. key_next and key_prev pulses in the same cycle -> req_ch unchanged. Key low for only 3 cycles -> no pulse.
6. Assert reset while switch_pending = 1 -> all outputs return to reset values immediately; no switch follows subsequent vsync rises.
